// File: rtl/klavye_pkg.sv
// Shared types and constants for the keyboard arbiter and its password listener.
package klavye_pkg;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    YUKLE  = 2'd1,
    GONDER = 2'd2
  } hakem_durum_t;

  localparam int N_KAYNAK_VARSAYILAN   = 2;
  localparam int SIFRE_BAYT_VARSAYILAN = 4;

  // Listener-side constants, kept here so both blocks agree on them.
  localparam int         DINLEYICI_HATA_SINIRI = 3;
  localparam logic [7:0] DINLEYICI_ONAY_TUSU   = 8'h0D;

  function automatic int sonraki_ptr(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/klavye_rr_secici.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module klavye_rr_secici
  import klavye_pkg::*;
#(
  parameter int N_KAYNAK = N_KAYNAK_VARSAYILAN,
  parameter int PW       = 1
) (
  input  logic [N_KAYNAK-1:0] istek_i,
  input  logic [PW-1:0]       ptr_i,
  output logic [N_KAYNAK-1:0] kabul_o,
  output logic                gecerli_o
);

  always_comb begin
    int idx;
    kabul_o   = '0;
    gecerli_o = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_KAYNAK; k++) begin
      idx = (int'(ptr_i) + k) % N_KAYNAK;
      if (!gecerli_o && istek_i[idx]) begin
        kabul_o[idx] = 1'b1;
        gecerli_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/klavye_hakem.sv
// Keyboard arbiter: round-robin key bytes to the listener, with priority
// for streaming a new password into it byte by byte.
//
// state  | meaning
// BOSTA  | idle; accepts a password update or grants one key request
// YUKLE  | streaming captured password, MSB first, SIFRE_BAYT cycles
// GONDER | presenting the latched key byte for one cycle
module klavye_hakem
  import klavye_pkg::*;
#(
  parameter int N_KAYNAK   = N_KAYNAK_VARSAYILAN,
  parameter int SIFRE_BAYT = SIFRE_BAYT_VARSAYILAN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_KAYNAK-1:0]     istek,
  input  logic [8*N_KAYNAK-1:0]   karakter_in,
  output logic [N_KAYNAK-1:0]     kabul,
  input  logic                    sifre_istek,
  input  logic [8*SIFRE_BAYT-1:0] sifre_yeni,
  output logic                    sifre_hazir,
  input  logic                    kitle,
  output logic [7:0]              karakter,
  output logic                    karakter_aktif,
  output logic [7:0]              sifre_kanali,
  output logic                    sifre_degis,
  output logic                    mesgul
);

  localparam int SW = $clog2(SIFRE_BAYT + 1);
  localparam int PW = (N_KAYNAK > 1) ? $clog2(N_KAYNAK) : 1;

  hakem_durum_t            durum_q, durum_d;
  logic [SW-1:0]           sayac_q, sayac_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [8*SIFRE_BAYT-1:0] sifre_q, sifre_d;
  logic [7:0]              bayt_q, bayt_d;
  logic [7:0]              son_kar_q, son_kar_d;
  logic [7:0]              son_sifre_q, son_sifre_d;

  logic [N_KAYNAK-1:0]     rr_kabul;
  logic                    rr_gecerli;
  logic                    sifre_kabul;
  logic                    hakem_izin;
  logic                    son_bayt;
  logic [PW-1:0]           secilen;
  logic [7:0]              secilen_bayt;
  logic [7:0]              yuk_bayt;

  klavye_rr_secici #(
    .N_KAYNAK (N_KAYNAK),
    .PW       (PW)
  ) u_secici (
    .istek_i   (istek),
    .ptr_i     (ptr_q),
    .kabul_o   (rr_kabul),
    .gecerli_o (rr_gecerli)
  );

  // Password update wins over any key request in the same idle cycle.
  assign sifre_kabul = sifre_istek && (durum_q == BOSTA);
  assign hakem_izin  = (durum_q == BOSTA) && !sifre_kabul && !kitle && rr_gecerli;
  assign son_bayt    = (sayac_q == SW'(SIFRE_BAYT - 1));
  assign yuk_bayt    = sifre_q[8*(SIFRE_BAYT-1-int'(sayac_q)) +: 8];

  always_comb begin
    secilen      = '0;
    secilen_bayt = '0;
    for (int i = 0; i < N_KAYNAK; i++) begin
      if (rr_kabul[i]) begin
        secilen      = PW'(i);
        secilen_bayt = karakter_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) durum_q <= BOSTA;
    else     durum_q <= durum_d;
  end

  always_comb begin
    durum_d = durum_q;
    unique case (durum_q)
      BOSTA: begin
        if (sifre_kabul)     durum_d = YUKLE;
        else if (hakem_izin) durum_d = GONDER;
      end
      YUKLE:   if (son_bayt) durum_d = BOSTA;
      GONDER:  durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase
  end

  always_comb begin
    mesgul         = (durum_q != BOSTA);
    sifre_hazir    = (durum_q == BOSTA);
    kabul          = (hakem_izin && !rst) ? rr_kabul : '0;
    karakter_aktif = (durum_q == GONDER);
    karakter       = karakter_aktif ? bayt_q : son_kar_q;
    sifre_degis    = (durum_q == YUKLE);
    sifre_kanali   = sifre_degis ? yuk_bayt : son_sifre_q;
  end

  always_comb begin
    sayac_d     = sayac_q;
    ptr_d       = ptr_q;
    sifre_d     = sifre_q;
    bayt_d      = bayt_q;
    son_kar_d   = son_kar_q;
    son_sifre_d = son_sifre_q;
    if (sifre_kabul) begin
      sifre_d = sifre_yeni;
      sayac_d = '0;
    end else if (hakem_izin) begin
      bayt_d = secilen_bayt;
      ptr_d  = PW'(sonraki_ptr(int'(secilen), N_KAYNAK));
    end
    if (durum_q == YUKLE) begin
      son_sifre_d = yuk_bayt;
      sayac_d     = son_bayt ? '0 : sayac_q + 1'b1;
    end
    // Hold registers remember the last strobed byte so outputs stay stable.
    if (durum_q == GONDER) son_kar_d = bayt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sayac_q     <= '0;
      ptr_q       <= '0;
      sifre_q     <= '0;
      bayt_q      <= '0;
      son_kar_q   <= '0;
      son_sifre_q <= '0;
    end else begin
      sayac_q     <= sayac_d;
      ptr_q       <= ptr_d;
      sifre_q     <= sifre_d;
      bayt_q      <= bayt_d;
      son_kar_q   <= son_kar_d;
      son_sifre_q <= son_sifre_d;
    end
  end

endmodule

// File: tb/tb_klavye_hakem.sv
// Scoreboard bench for klavye_hakem: stimulus queues expected strobes with
// their cycle numbers, a negedge monitor pops and compares them.
module tb_klavye_hakem;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  istek;
  logic [15:0] karakter_in;
  logic [1:0]  kabul;
  logic        sifre_istek;
  logic [31:0] sifre_yeni;
  logic        sifre_hazir;
  logic        kitle;
  logic [7:0]  karakter;
  logic        karakter_aktif;
  logic [7:0]  sifre_kanali;
  logic        sifre_degis;
  logic        mesgul;

  klavye_hakem #(.N_KAYNAK(2), .SIFRE_BAYT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .istek          (istek),
    .karakter_in    (karakter_in),
    .kabul          (kabul),
    .sifre_istek    (sifre_istek),
    .sifre_yeni     (sifre_yeni),
    .sifre_hazir    (sifre_hazir),
    .kitle          (kitle),
    .karakter       (karakter),
    .karakter_aktif (karakter_aktif),
    .sifre_kanali   (sifre_kanali),
    .sifre_degis    (sifre_degis),
    .mesgul         (mesgul)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit basladi = 1'b0;

  typedef struct {
    logic [7:0] v;
    int         c;
  } bek_t;

  bek_t q_kar[$];
  bek_t q_sif[$];
  bek_t q_kab[$];

  function automatic bek_t bek(input logic [7:0] v, input int c);
    bek_t b;
    b.v = v;
    b.c = c;
    return b;
  endfunction

  task automatic tik(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string ad, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", ad, got, want, cyc);
    end
  endtask

  task automatic reset_degerleri(input string ad);
    chk({ad, "_kabul"},          32'(kabul),          32'h0);
    chk({ad, "_karakter"},       32'(karakter),       32'h0);
    chk({ad, "_karakter_aktif"}, 32'(karakter_aktif), 32'h0);
    chk({ad, "_sifre_kanali"},   32'(sifre_kanali),   32'h0);
    chk({ad, "_sifre_degis"},    32'(sifre_degis),    32'h0);
    chk({ad, "_mesgul"},         32'(mesgul),         32'h0);
    chk({ad, "_sifre_hazir"},    32'(sifre_hazir),    32'h1);
  endtask

  always @(negedge clk) begin : monitor
    bek_t e;
    if (basladi) begin
      if (kabul !== 2'b00) begin
        total++;
        if (q_kab.size() == 0) begin
          bad++;
          $display("FAIL kabul_unexpected got=%b at cycle %0d", kabul, cyc);
        end else begin
          e = q_kab.pop_front();
          if (kabul !== (2'b01 << e.v[0]) || cyc != e.c) begin
            bad++;
            $display("FAIL kabul got=%b@%0d want bit%0d@%0d", kabul, cyc, e.v, e.c);
          end
        end
      end
      if (karakter_aktif === 1'b1) begin
        total++;
        if (q_kar.size() == 0) begin
          bad++;
          $display("FAIL karakter_unexpected got=%h at cycle %0d", karakter, cyc);
        end else begin
          e = q_kar.pop_front();
          if (karakter !== e.v || cyc != e.c) begin
            bad++;
            $display("FAIL karakter got=%h@%0d want=%h@%0d", karakter, cyc, e.v, e.c);
          end
        end
      end
      if (sifre_degis === 1'b1) begin
        total++;
        if (q_sif.size() == 0) begin
          bad++;
          $display("FAIL sifre_unexpected got=%h at cycle %0d", sifre_kanali, cyc);
        end else begin
          e = q_sif.pop_front();
          if (sifre_kanali !== e.v || cyc != e.c) begin
            bad++;
            $display("FAIL sifre got=%h@%0d want=%h@%0d", sifre_kanali, cyc, e.v, e.c);
          end
        end
        total++;
        if (mesgul !== 1'b1 || sifre_hazir !== 1'b0) begin
          bad++;
          $display("FAIL yukle_bayrak got mesgul=%b hazir=%b want mesgul=1 hazir=0 at cycle %0d",
                   mesgul, sifre_hazir, cyc);
        end
      end
    end
  end

  initial begin
    int c;
    rst = 1'b1; istek = '0; karakter_in = '0;
    sifre_istek = 1'b0; sifre_yeni = '0; kitle = 1'b0;
    tik(3);
    rst = 1'b0;
    basladi = 1'b1;
    @(negedge clk);
    reset_degerleri("reset");
    tik();

    // Password load with kitle held high: must neither abort nor stall.
    c = cyc;
    sifre_yeni = 32'h41424344; sifre_istek = 1'b1; kitle = 1'b1;
    for (int i = 0; i < 4; i++) q_sif.push_back(bek(8'(8'h41 + i), c + 1 + i));
    tik();
    sifre_istek = 1'b0;
    tik(4);
    kitle = 1'b0;
    @(negedge clk);
    chk("sifre_tut", 32'(sifre_kanali), 32'h44);
    chk("yukle_bitti_mesgul", 32'(mesgul), 32'h0);
    tik();

    // Both requesters held: strict alternation, one byte per two cycles.
    c = cyc;
    istek = 2'b11; karakter_in = 16'h6261;
    q_kab.push_back(bek(8'd0, c));     q_kar.push_back(bek(8'h61, c + 1));
    q_kab.push_back(bek(8'd1, c + 2)); q_kar.push_back(bek(8'h62, c + 3));
    q_kab.push_back(bek(8'd0, c + 4)); q_kar.push_back(bek(8'h61, c + 5));
    q_kab.push_back(bek(8'd1, c + 6)); q_kar.push_back(bek(8'h62, c + 7));
    tik(7);
    istek = 2'b00;
    tik();
    @(negedge clk);
    chk("karakter_tut", 32'(karakter), 32'h62);
    tik();

    // Password request and key request together: load first, then grant.
    c = cyc;
    sifre_yeni = 32'hA1B2C3D4; sifre_istek = 1'b1;
    istek = 2'b01; karakter_in = 16'h0055;
    q_sif.push_back(bek(8'hA1, c + 1)); q_sif.push_back(bek(8'hB2, c + 2));
    q_sif.push_back(bek(8'hC3, c + 3)); q_sif.push_back(bek(8'hD4, c + 4));
    q_kab.push_back(bek(8'd0, c + 5));  q_kar.push_back(bek(8'h55, c + 6));
    tik();
    sifre_istek = 1'b0;
    tik(5);
    istek = 2'b00;
    tik(2);

    // Lock-out for 20 cycles; grant must come in the first unlocked cycle.
    c = cyc;
    kitle = 1'b1; istek = 2'b10; karakter_in = 16'h7700;
    q_kab.push_back(bek(8'd1, c + 20)); q_kar.push_back(bek(8'h77, c + 21));
    tik(20);
    kitle = 1'b0;
    tik();
    istek = 2'b00;
    tik(2);

    // kitle rising as GONDER is entered must not swallow the byte.
    c = cyc;
    istek = 2'b01; karakter_in = 16'h0066;
    q_kab.push_back(bek(8'd0, c)); q_kar.push_back(bek(8'h66, c + 1));
    tik();
    kitle = 1'b1; istek = 2'b00;
    tik();
    kitle = 1'b0;
    tik();

    // Pointer now at 1: search starts there and wraps to 0.
    c = cyc;
    istek = 2'b11; karakter_in = 16'hBBAA;
    q_kab.push_back(bek(8'd1, c));     q_kar.push_back(bek(8'hBB, c + 1));
    q_kab.push_back(bek(8'd0, c + 2)); q_kar.push_back(bek(8'hAA, c + 3));
    tik(3);
    istek = 2'b00;
    tik(2);

    // Reset during the second password byte aborts the load.
    c = cyc;
    sifre_yeni = 32'h11223344; sifre_istek = 1'b1;
    q_sif.push_back(bek(8'h11, c + 1)); q_sif.push_back(bek(8'h22, c + 2));
    tik();
    sifre_istek = 1'b0;
    tik();
    rst = 1'b1;
    tik();
    rst = 1'b0;
    @(negedge clk);
    reset_degerleri("abort");
    tik();

    c = cyc;
    sifre_yeni = 32'h55667788; sifre_istek = 1'b1;
    for (int i = 0; i < 4; i++) q_sif.push_back(bek(8'(8'h55 + 8'h11 * i), c + 1 + i));
    tik();
    sifre_istek = 1'b0;
    tik(5);

    // Pointer was cleared by reset: requester 0 is served first.
    c = cyc;
    istek = 2'b11; karakter_in = 16'hD2D1;
    q_kab.push_back(bek(8'd0, c)); q_kar.push_back(bek(8'hD1, c + 1));
    tik();
    istek = 2'b00;
    tik(3);

    chk("kuyruk_bos", 32'(q_kar.size() + q_sif.size() + q_kab.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/klavye_hakem.md
KLAVYE_HAKEM -- requirements
Module: klavye_hakem

Interface
REQ-001 The module SHALL have parameter N_KAYNAK, default 2, number of keyboard requesters (2..8).
REQ-002 The module SHALL have parameter SIFRE_BAYT, default 4, password length in bytes, MSB first.
REQ-003 clk  in  1  single clock; every register SHALL update on its rising edge only.
REQ-004 rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 istek  in  N_KAYNAK  per-requester key-byte request; held high until granted.
REQ-006 karakter_in  in  8*N_KAYNAK  key bytes; requester i uses bits [8i+7:8i].
REQ-007 kabul  out  N_KAYNAK  one-hot, one-cycle grant pulse to the served requester.
REQ-008 sifre_istek  in  1  password-update request; the update is accepted when sifre_istek and sifre_hazir are both 1.
REQ-009 sifre_yeni  in  8*SIFRE_BAYT  new password, captured at acceptance.
REQ-010 sifre_hazir  out  1  high only in BOSTA, meaning a password update can be accepted.
REQ-011 kitle  in  1  lock-out flag from the listener.
REQ-012 karakter  out  8  byte forwarded to the listener.
REQ-013 karakter_aktif  out  1  one-cycle strobe qualifying karakter.
REQ-014 sifre_kanali  out  8  password byte to the listener.
REQ-015 sifre_degis  out  1  strobe qualifying sifre_kanali, high for SIFRE_BAYT consecutive cycles per update.
REQ-016 mesgul  out  1  high in any state other than BOSTA.

Function
REQ-017 The controller SHALL have the states BOSTA, YUKLE and GONDER.
REQ-018 In BOSTA, an accepted sifre_istek SHALL capture sifre_yeni and move to YUKLE with byte counter 0.
- Password update has priority over every istek bit in the same cycle.
REQ-019 YUKLE SHALL last exactly SIFRE_BAYT cycles and drive sifre_degis=1 in each of them.
- sifre_kanali = captured byte [counter], most significant byte first.
- After the last byte the state returns to BOSTA.
REQ-020 While in YUKLE, kabul SHALL be 0 and karakter_aktif SHALL be 0.
- Pending istek stays pending; no request is lost.
REQ-021 kitle=1 SHALL NOT abort or stall YUKLE.
REQ-022 In BOSTA with no accepted password update, kitle=0 and any istek bit set, the arbiter SHALL select one requester round-robin.
- Search starts at pointer ptr and goes upward, wrapping at N_KAYNAK-1 to 0.
- The selected byte is latched, the state moves to GONDER, and kabul[i] pulses in the same cycle.
REQ-023 After each grant to requester i, ptr SHALL become (i+1) mod N_KAYNAK.
REQ-024 GONDER SHALL last one cycle: karakter = latched byte, karakter_aktif=1, then the state returns to BOSTA.
- Maximum key rate is therefore one byte per 2 cycles.
REQ-025 While kitle=1, no grant SHALL be issued; requests wait and are not dropped or reordered.
REQ-026 If kitle rises in the cycle GONDER is entered, the latched byte SHALL still be delivered.
REQ-027 kabul SHALL never have more than one bit set, and SHALL be 0 in any cycle without a grant.
REQ-028 karakter and sifre_kanali SHALL hold their last driven value when their strobe is 0.
REQ-029 The byte counter SHALL be ceil(log2(SIFRE_BAYT+1)) bits, and ptr ceil(log2(N_KAYNAK)) bits.

Reset
REQ-030 rst=1 SHALL force the state to BOSTA, ptr=0, counter=0 and the captured password to 0.
- Outputs go to: kabul=0, karakter=0, karakter_aktif=0, sifre_kanali=0, sifre_degis=0, mesgul=0, sifre_hazir=1.
REQ-031 rst asserted mid-YUKLE or mid-GONDER SHALL abort the transfer; no further strobe is produced.
REQ-032 rst SHALL take priority over all other inputs in the same cycle.

Structure
REQ-033 The state encoding and default parameter values SHALL live in the shared package klavye_pkg, alongside the listener's constants.
REQ-034 The round-robin selection SHALL be a sub-module, klavye_rr_secici.
- Inputs: istek and ptr.
- Outputs: one-hot grant and a valid flag; purely combinational.
- The parent owns all registers.

Verification
REQ-035 Reset, then sifre_istek with sifre_yeni=32'h41424344: sifre_degis high for 4 cycles carrying 41,42,43,44; mesgul high for the same 4 cycles; sifre_hazir=0 during them.
REQ-036 istek=2'b11 held with karakter_in={8'h62,8'h61}: grants alternate 0,1,0,1, one every 2 cycles; karakter sequence 61,62,61,62.
REQ-037 sifre_istek and istek[0] in the same BOSTA cycle: the 4-byte load completes first; kabul[0] pulses in the first BOSTA cycle afterward.
REQ-038 kitle=1 for 20 cycles with istek[1]=1: no kabul and no karakter_aktif; first kabul[1] in the first cycle kitle=0.
REQ-039 rst pulsed during byte 2 of a load: sifre_degis=0 from the next cycle; all outputs at reset values; a subsequent load restarts at byte 0.
